// File: rtl/ox_tx_stream_arb_pkg.sv
// Shared definitions for the OmniXtend transmit stream arbiter.
// FSM encoding, tDest mode selectors and a width helper.
package ox_tx_stream_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    localparam int DEST_MODE_PASS = 0;
    localparam int DEST_MODE_IDX  = 1;

    function automatic int ox_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ox_tx_stream_arb_rr_pick.sv
// Combinational round-robin selector: first requester found
// searching upward from the source after last_grant, wrapping.
module ox_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   grant,
    output logic              any_req
);

    logic [CH_W:0] cand;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = {1'b0, last_grant} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!any_req && req[cand[CH_W-1:0]]) begin
                grant   = cand[CH_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ox_tx_stream_arb.sv
// Frame-granular round-robin merge of NUM_CH AXI-Stream sources
// onto the SFP transmit stream, with a fully registered output.
module ox_tx_stream_arb
    import ox_tx_stream_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 64,
    parameter int DEST_W    = 4,
    parameter int DEST_MODE = 0
) (
    input  logic                       sfp_axis_tx_aclk,
    input  logic                       sfp_axis_tx_aresetn,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic [NUM_CH-1:0]          s_axis_tvalid,
    output logic [NUM_CH-1:0]          s_axis_tready,
    input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_CH*DATA_W/8-1:0] s_axis_tkeep,
    input  logic [NUM_CH-1:0]          s_axis_tlast,
    input  logic [NUM_CH*DEST_W-1:0]   s_axis_tDest,
    output logic                       sfp_axis_tx_tvalid,
    input  logic                       sfp_axis_tx_tready,
    output logic [DATA_W-1:0]          sfp_axis_tx_tdata,
    output logic [DATA_W/8-1:0]        sfp_axis_tx_tkeep,
    output logic                       sfp_axis_tx_tlast,
    output logic [DEST_W-1:0]          sfp_axis_tx_tDest,
    output logic                       busy,
    output logic [ox_clog2(NUM_CH)-1:0] cur_ch,
    output logic [31:0]                frame_cnt
);

    localparam int CH_W   = ox_clog2(NUM_CH);
    localparam int KEEP_W = DATA_W / 8;

    logic [0:0]        state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   pick;
    logic              any_req;
    logic [NUM_CH-1:0] req;
    logic              out_ready;
    logic              accept;

    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic [DEST_W-1:0] sel_dest;

    assign req       = s_axis_tvalid & ch_en;
    assign out_ready = !sfp_axis_tx_tvalid || sfp_axis_tx_tready;
    assign accept    = (state == ST_XFER) && sel_valid && out_ready;
    assign busy      = (state == ST_XFER);
    assign cur_ch    = grant;

    ox_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (any_req)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_dest  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant == CH_W'(c)) begin
                sel_valid = s_axis_tvalid[c];
                sel_last  = s_axis_tlast[c];
                sel_data  = s_axis_tdata[c*DATA_W +: DATA_W];
                sel_keep  = s_axis_tkeep[c*KEEP_W +: KEEP_W];
                sel_dest  = s_axis_tDest[c*DEST_W +: DEST_W];
            end
        end
        if (DEST_MODE == DEST_MODE_IDX) begin
            sel_dest = DEST_W'(grant);
        end
    end

    // Only the owner sees ready; it follows the output slot combinationally.
    always_comb begin
        s_axis_tready = '0;
        if (state == ST_XFER) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (grant == CH_W'(c)) begin
                    s_axis_tready[c] = out_ready;
                end
            end
        end
    end

    always_ff @(posedge sfp_axis_tx_aclk or negedge sfp_axis_tx_aresetn) begin
        if (!sfp_axis_tx_aresetn) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant <= pick;
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept && sel_last) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sfp_axis_tx_aclk or negedge sfp_axis_tx_aresetn) begin
        if (!sfp_axis_tx_aresetn) begin
            sfp_axis_tx_tvalid <= 1'b0;
            sfp_axis_tx_tdata  <= '0;
            sfp_axis_tx_tkeep  <= '0;
            sfp_axis_tx_tlast  <= 1'b0;
            sfp_axis_tx_tDest  <= '0;
        end else if (accept) begin
            sfp_axis_tx_tvalid <= 1'b1;
            sfp_axis_tx_tdata  <= sel_data;
            sfp_axis_tx_tkeep  <= sel_keep;
            sfp_axis_tx_tlast  <= sel_last;
            sfp_axis_tx_tDest  <= sel_dest;
        end else if (sfp_axis_tx_tready) begin
            sfp_axis_tx_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge sfp_axis_tx_aclk or negedge sfp_axis_tx_aresetn) begin
        if (!sfp_axis_tx_aresetn) begin
            frame_cnt <= '0;
        end else if (sfp_axis_tx_tvalid && sfp_axis_tx_tready && sfp_axis_tx_tlast) begin
            frame_cnt <= frame_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ox_tx_stream_arb.sv
// Bench for ox_tx_stream_arb: queued source frames, a frame-level
// round-robin reference and an output scoreboard.
module tb_ox_tx_stream_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   ch_en;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready0;
    logic [3:0]   s_ready1;
    logic [255:0] s_data;
    logic [31:0]  s_keep;
    logic [3:0]   s_last;
    logic [15:0]  s_dest;
    logic         tready;
    logic         tv0, tv1, tl0, tl1, busy0, busy1;
    logic [63:0]  td0, td1;
    logic [7:0]   tk0, tk1;
    logic [3:0]   tdst0, tdst1;
    logic [1:0]   cur0, cur1;
    logic [31:0]  fc0, fc1;

    always #5 clk = ~clk;

    ox_tx_stream_arb #(.NUM_CH(4), .DATA_W(64), .DEST_W(4), .DEST_MODE(0)) u_dut (
        .sfp_axis_tx_aclk(clk), .sfp_axis_tx_aresetn(rst_n), .ch_en(ch_en),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready0), .s_axis_tdata(s_data),
        .s_axis_tkeep(s_keep), .s_axis_tlast(s_last), .s_axis_tDest(s_dest),
        .sfp_axis_tx_tvalid(tv0), .sfp_axis_tx_tready(tready),
        .sfp_axis_tx_tdata(td0), .sfp_axis_tx_tkeep(tk0), .sfp_axis_tx_tlast(tl0),
        .sfp_axis_tx_tDest(tdst0), .busy(busy0), .cur_ch(cur0), .frame_cnt(fc0)
    );

    ox_tx_stream_arb #(.NUM_CH(4), .DATA_W(64), .DEST_W(4), .DEST_MODE(1)) u_dut_idx (
        .sfp_axis_tx_aclk(clk), .sfp_axis_tx_aresetn(rst_n), .ch_en(ch_en),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready1), .s_axis_tdata(s_data),
        .s_axis_tkeep(s_keep), .s_axis_tlast(s_last), .s_axis_tDest(s_dest),
        .sfp_axis_tx_tvalid(tv1), .sfp_axis_tx_tready(tready),
        .sfp_axis_tx_tdata(td1), .sfp_axis_tx_tkeep(tk1), .sfp_axis_tx_tlast(tl1),
        .sfp_axis_tx_tDest(tdst1), .busy(busy1), .cur_ch(cur1), .frame_cnt(fc1)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  dest;
    } beat_t;

    typedef struct packed {
        beat_t      b;
        logic [1:0] src;
    } exp_t;

    beat_t srcq [4][$];
    exp_t  expq[$];
    int    glog[$];

    int    total = 0;
    int    bad = 0;
    int    m_last = 3;
    int    m_owner = 0;
    bit    m_busy = 0;
    bit    m_armed = 0;
    int    m_frames = 0;
    int    m_beats = 0;
    bit    mid [4];
    int    cyc = 0;
    int    first_out = -1;
    int    last_out = -1;
    bit    hold_p = 0;
    beat_t hold_b;
    int    bubble_pct = 0;
    int    tr_mode = 0;
    int    force_dest = -1;
    logic [3:0] last_dest0, last_dest1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (req[2'((last + k) % 4)]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic int pending();
        return srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size();
    endfunction

    task automatic add_frame(input int ch, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {$urandom, $urandom};
            b.keep = (k == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
            b.last = (k == len - 1);
            b.dest = (force_dest >= 0) ? 4'(force_dest) : 4'($urandom);
            srcq[ch].push_back(b);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            logic v;
            v = (srcq[i].size() > 0) &&
                (!mid[i] || int'($urandom_range(0, 99)) >= bubble_pct);
            s_valid[i] = v;
            if (srcq[i].size() > 0) begin
                s_data[i*64 +: 64] = srcq[i][0].data;
                s_keep[i*8 +: 8]   = srcq[i][0].keep;
                s_last[i]          = srcq[i][0].last;
                s_dest[i*4 +: 4]   = srcq[i][0].dest;
            end
        end
        case (tr_mode)
            0: tready = 1'b1;
            1: tready = ~tready;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic cycle();
        logic [3:0] req, hs_in, exp_rdy;
        logic       hs_out, eb;
        beat_t      ob, b;
        exp_t       e;
        @(negedge clk);
        cyc++;
        req    = s_valid & ch_en;
        hs_in  = s_valid & s_ready0;
        hs_out = tv0 & tready;
        ob     = {td0, tk0, tl0, tdst0};
        eb     = m_busy || m_armed;
        exp_rdy = (eb && (!tv0 || tready)) ? 4'(1 << m_owner) : 4'b0;
        chk("busy", 128'(busy0), 128'(eb));
        chk("s_ready", 128'(s_ready0), 128'(exp_rdy));
        if (eb) chk("cur_ch", 128'(cur0), 128'(m_owner));
        chk("frame_cnt", 128'(fc0), 128'(m_frames));
        if (hold_p) begin
            chk("hold_valid", 128'(tv0), 128'(1));
            chk("hold_beat", 128'(ob), 128'(hold_b));
        end
        hold_p = tv0 && !tready;
        hold_b = ob;
        if (!eb && req != 4'b0) begin
            m_owner = rr_pick(req, m_last);
            m_armed = 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (hs_in[i] && srcq[i].size() > 0) begin
                if (m_armed) begin
                    chk("grant", 128'(i), 128'(m_owner));
                    glog.push_back(i);
                    m_armed = 0;
                    m_busy = 1;
                end
                b = srcq[i].pop_front();
                e.b = b;
                e.src = 2'(i);
                expq.push_back(e);
                mid[i] = !b.last;
                if (b.last) begin
                    m_busy = 0;
                    m_last = i;
                end
            end
        end
        if (hs_out) begin
            chk("out_avail", 128'(expq.size() > 0), 128'(1));
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("out_beat", 128'(ob), 128'(e.b));
                chk("dest_idx", 128'(tdst1), 128'(e.src));
                m_beats++;
                if (e.b.last) m_frames++;
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            last_dest0 = tdst0;
            last_dest1 = tdst1;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((pending() > 0 || expq.size() > 0 || m_busy || m_armed) && k < budget) begin
            cycle();
            k++;
        end
        chk("drain_timeout", 128'(k < budget), 128'(1));
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (check) begin
            chk("rst_tvalid", 128'(tv0), 128'(0));
            chk("rst_tdata", 128'(td0), 128'(0));
            chk("rst_tkeep", 128'(tk0), 128'(0));
            chk("rst_tlast", 128'(tl0), 128'(0));
            chk("rst_tdest", 128'(tdst0), 128'(0));
            chk("rst_sready", 128'(s_ready0), 128'(0));
            chk("rst_busy", 128'(busy0), 128'(0));
            chk("rst_cur_ch", 128'(cur0), 128'(0));
            chk("rst_frame_cnt", 128'(fc0), 128'(0));
        end
        for (int i = 0; i < 4; i++) begin
            srcq[i].delete();
            mid[i] = 0;
        end
        expq.delete();
        glog.delete();
        m_last = 3;
        m_busy = 0;
        m_armed = 0;
        m_frames = 0;
        hold_p = 0;
        first_out = -1;
        s_valid = 4'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int k, b0, f0;
        int exp_order[$];
        ch_en = 4'hF;
        s_valid = '0;
        s_data = '0;
        s_keep = '0;
        s_last = '0;
        s_dest = '0;
        tready = 1'b1;
        do_reset(1);

        // reset mid-frame on source 2, then 0 must win over 2
        add_frame(2, 4);
        drive();
        run(4);
        chk("pre_rst_busy", 128'(busy0), 128'(1));
        do_reset(1);
        add_frame(2, 2);
        add_frame(0, 2);
        drive();
        drain(200);
        chk("rst_nfr", 128'(glog.size()), 128'(2));
        chk("rst_first", 128'(glog[0]), 128'(0));
        chk("rst_second", 128'(glog[1]), 128'(2));

        // round robin with one gap cycle per frame boundary
        do_reset(0);
        add_frame(0, 3);
        add_frame(0, 3);
        add_frame(1, 3);
        add_frame(2, 3);
        add_frame(3, 3);
        drive();
        drain(300);
        run(2);
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_nfr", 128'(glog.size()), 128'(5));
        for (int i = 0; i < 5; i++) chk("rr_order", 128'(glog[i]), 128'(exp_order[i]));
        chk("rr_span", 128'(last_out - first_out + 1), 128'(19));
        chk("rr_frame_cnt", 128'(fc0), 128'(5));

        // backpressure toggling every cycle
        tr_mode = 1;
        b0 = m_beats;
        add_frame(1, 8);
        drive();
        drain(200);
        chk("bp_beats", 128'(m_beats - b0), 128'(8));
        chk("bp_src", 128'(glog[glog.size() - 1]), 128'(1));
        tr_mode = 0;

        // enable mask and mid-frame enable change
        do_reset(0);
        ch_en = 4'b1011;
        add_frame(0, 2);
        add_frame(1, 6);
        add_frame(2, 2);
        add_frame(3, 2);
        drive();
        k = 0;
        while (glog.size() < 2 && k < 50) begin cycle(); k++; end
        run(2);
        ch_en = 4'b1001;
        while (glog.size() < 3 && k < 100) begin cycle(); k++; end
        chk("en_timeout", 128'(k < 100), 128'(1));
        run(10);
        exp_order = '{0, 1, 3};
        chk("en_nfr", 128'(glog.size()), 128'(3));
        for (int i = 0; i < 3; i++) chk("en_order", 128'(glog[i]), 128'(exp_order[i]));
        chk("en_src2_held", 128'(srcq[2].size()), 128'(2));
        ch_en = 4'hF;
        drain(200);
        chk("en_src2_late", 128'(glog[3]), 128'(2));

        // tDest pass-through vs source index
        force_dest = 10;
        add_frame(3, 1);
        force_dest = -1;
        drive();
        drain(100);
        chk("dest_pass", 128'(last_dest0), 128'(4'hA));
        chk("dest_idx3", 128'(last_dest1), 128'(4'h3));

        // alternating single-beat frames
        glog.delete();
        f0 = m_frames;
        for (int i = 0; i < 4; i++) begin
            add_frame(0, 1);
            add_frame(1, 1);
        end
        drive();
        drain(200);
        run(2);
        chk("sb_nfr", 128'(glog.size()), 128'(8));
        for (int i = 0; i < 8; i++) chk("sb_order", 128'(glog[i]), 128'(i % 2));
        chk("sb_frame_cnt", 128'(fc0), 128'(f0 + 8));

        // randomized traffic, bubbles, backpressure and enable churn
        bubble_pct = 30;
        tr_mode = 2;
        for (int n = 0; n < 40; n++) begin
            add_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
            if (n % 8 == 3) ch_en = 4'($urandom_range(1, 15));
            if (n % 8 == 6) ch_en = 4'hF;
            run(int'($urandom_range(0, 5)));
        end
        ch_en = 4'hF;
        drain(3000);
        tr_mode = 0;
        run(2);
        chk("rand_frames", 128'(fc0), 128'(m_frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ox_tx_stream_arb.md
# ox_tx_stream_arb

Parametrised packet-level arbiter merging NUM_CH independent AXI-Stream transmit sources, one per OmniXtend channel/queue, onto the single SFP transmit AXI-Stream of the endpoint. Arbitration is round-robin at frame granularity: a granted source owns the output until its tlast beat is accepted. The output is fully registered. The block sits between the endpoint's per-channel frame builders and the MAC-side `sfp_axis_tx_*` port.

## Interface
- NUM_CH, 4, number of input sources (2..16)
- DATA_W, 64, tdata width in bits (multiple of 8)
- DEST_W, 4, tDest width
- DEST_MODE, 0, 0 = pass source tDest through; 1 = replace tDest with source index (zero-extended)
- sfp_axis_tx_aclk  in  1  sole clock
- sfp_axis_tx_aresetn  in  1  asynchronous active-low reset
- ch_en  in  NUM_CH  per-source arbitration enable
- s_axis_tvalid  in  NUM_CH  source valid, bit i = source i
- s_axis_tready  out  NUM_CH  source ready
- s_axis_tdata  in  NUM_CH*DATA_W  packed, source i at [i*DATA_W +: DATA_W]
- s_axis_tkeep  in  NUM_CH*DATA_W/8  packed likewise
- s_axis_tlast  in  NUM_CH  frame end
- s_axis_tDest  in  NUM_CH*DEST_W  packed likewise
- sfp_axis_tx_tvalid  out  1  output valid (registered)
- sfp_axis_tx_tready  in  1  output ready
- sfp_axis_tx_tdata  out  DATA_W  output data (registered)
- sfp_axis_tx_tkeep  out  DATA_W/8  output keep (registered)
- sfp_axis_tx_tlast  out  1  output last (registered)
- sfp_axis_tx_tDest  out  DEST_W  output dest (registered)
- busy  out  1  high while in XFER
- cur_ch  out  clog2(NUM_CH)  currently/last granted source
- frame_cnt  out  32  frames forwarded (tlast beats accepted at output), wraps at 2^32

## Operation
- FSM states IDLE, XFER.
- IDLE: request vector = s_axis_tvalid & ch_en. If non-zero, grant = first set bit searching upward from (last_grant+1) mod NUM_CH, wrapping; register grant, go XFER. No beat is accepted in IDLE.
- XFER: s_axis_tready[grant] = out_ready, where out_ready = !sfp_axis_tx_tvalid || sfp_axis_tx_tready; all other s_axis_tready = 0. Accepted beat (valid & ready) loads output register; tDest per DEST_MODE. Accepted beat with tlast: last_grant <= grant, go IDLE.
- Output register: loads on accepted input beat; clears tvalid when sfp_axis_tx_tready is high and no new beat loads. Data/keep/last/dest hold stable while tvalid && !tready.
- ch_en change mid-frame does not abort the frame; takes effect at next IDLE arbitration.
- Source deasserting tvalid mid-frame: grant held, output bubbles, no re-arbitration.
- frame_cnt increments on sfp_axis_tx_tvalid & tready & tlast.
- Single-beat frames (tlast on first beat) are legal.

## Timing
- Reset values: sfp_axis_tx_tvalid 0, tdata/tkeep/tDest 0, tlast 0, s_axis_tready all 0, busy 0, cur_ch 0, frame_cnt 0, state IDLE, last_grant NUM_CH-1 (source 0 wins first arbitration).
- Latency: request seen in IDLE at cycle n -> grant registered, s_axis_tready[grant] high at n+1 -> beat on output at n+2.
- One idle cycle between back-to-back frames (IDLE arbitration cycle); sustained throughput otherwise 1 beat/cycle with sfp_axis_tx_tready held high.
- s_axis_tready depends combinationally on sfp_axis_tx_tready; no combinational path from any s_axis input to any output.
- Reset asserted mid-frame: all state cleared immediately; partial frame is not completed; arbitration restarts at source 0.

## Structure
- Shared package: FSM state encoding, DEST_MODE constants, clog2 helper function.
- One sub-module: ox_rr_pick, combinational round-robin selector (request vector, last_grant -> grant index, any_req).

## Test plan
- Reset: drive aresetn low mid-frame on source 2 -> all outputs zero next edge; after release, sources 0 and 2 requesting -> source 0 granted first.
- Round-robin: NUM_CH=4, all sources send 3-beat frames continuously, tready=1 -> output order 0,1,2,3,0 with one gap cycle between frames; frame_cnt = 5.
- Backpressure: toggle sfp_axis_tx_tready 1/0 each cycle during 8-beat frame on source 1 -> all 8 beats delivered in order, data stable while tready=0, no beat duplicated.
- Enable mask: ch_en=4'b1011 with all sources requesting -> source 2 never granted; clear bit 1 mid-frame of source 1 -> that frame completes, then source 3 granted.
- DEST_MODE=1: source 3 sends tDest=4'hA -> output tDest=4'h3; DEST_MODE=0 -> 4'hA.
- Single-beat frames from sources 0 and 1 alternately, tlast on every beat -> grants alternate 0,1,0,1; frame_cnt matches beat count.
